// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider job scheduler: default sizing and the
// legacy-compatible FSM state encoding.
package div_sched_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_TAG_WIDTH = 4;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] S_HOLD  = 2'd3;

  // Number of bits one queued job occupies: dividend, divisor and tag.
  function automatic int job_bits(input int width, input int tag_width);
    return 2 * width + tag_width;
  endfunction

endpackage

// File: rtl/div_job_scheduler_if.sv
// Bundles the producer, divider and consumer signals of the job scheduler.
// The scheduler uses the slave modport; its environment uses master.
interface div_job_scheduler_if
  import div_sched_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
);

  logic [WIDTH-1:0]     dividend_in;
  logic [WIDTH-1:0]     divisor_in;
  logic                 req_valid_in;
  logic                 req_ready_out;

  logic [WIDTH-1:0]     div_dividend_out;
  logic [WIDTH-1:0]     div_divisor_out;
  logic                 div_valid_out;
  logic                 div_busy_in;
  logic [WIDTH-1:0]     div_quotient_in;
  logic [WIDTH-1:0]     div_remainder_in;
  logic                 div_error_in;
  logic                 div_valid_in;

  logic [WIDTH-1:0]     quotient_out;
  logic [WIDTH-1:0]     remainder_out;
  logic                 error_out;
  logic [TAG_WIDTH-1:0] tag_out;
  logic                 result_valid_out;
  logic                 result_ready_in;

  modport slave (
    input  dividend_in, divisor_in, req_valid_in,
    output req_ready_out,
    output div_dividend_out, div_divisor_out, div_valid_out,
    input  div_busy_in, div_quotient_in, div_remainder_in, div_error_in, div_valid_in,
    output quotient_out, remainder_out, error_out, tag_out, result_valid_out,
    input  result_ready_in
  );

  modport master (
    output dividend_in, divisor_in, req_valid_in,
    input  req_ready_out,
    input  div_dividend_out, div_divisor_out, div_valid_out,
    output div_busy_in, div_quotient_in, div_remainder_in, div_error_in, div_valid_in,
    input  quotient_out, remainder_out, error_out, tag_out, result_valid_out,
    output result_ready_in
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer MSB to tell full from empty.
// Pushes while full and pops while empty are silently dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/div_job_scheduler.sv
// Queues tagged division jobs, feeds them one at a time to an iterative
// divider and holds each result until the consumer takes it.
module div_job_scheduler
  import div_sched_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic                clk_in,
  input  logic                rst_in,
  div_job_scheduler_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic [TAG_WIDTH-1:0] tag;
  } job_t;

  localparam int JOB_W = job_bits(WIDTH, TAG_WIDTH);

  job_t                 push_job;
  job_t                 head_job;
  logic [TAG_WIDTH-1:0] tag_cnt;
  logic [TAG_WIDTH-1:0] cur_tag;
  logic [STATE_W-1:0]   state;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  assign push              = bus.req_valid_in && !fifo_full;
  assign pop               = (state == S_IDLE) && !fifo_empty && !bus.div_busy_in;
  assign bus.req_ready_out = !fifo_full;
  assign bus.div_valid_out = (state == S_ISSUE);
  assign push_job          = {bus.dividend_in, bus.divisor_in, tag_cnt};

  sync_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (push),
    .pop     (pop),
    .wr_data (push_job),
    .rd_data (head_job),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Tags are handed out at acceptance so they follow producer order and wrap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + TAG_WIDTH'(1);
  end

  // ISSUE lasts exactly one cycle so the divider sees a single-cycle start
  // pulse even before its busy flag has risen.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                <= S_IDLE;
      cur_tag              <= '0;
      bus.div_dividend_out <= '0;
      bus.div_divisor_out  <= '0;
      bus.quotient_out     <= '0;
      bus.remainder_out    <= '0;
      bus.error_out        <= 1'b0;
      bus.tag_out          <= '0;
      bus.result_valid_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.div_dividend_out <= head_job.dividend;
            bus.div_divisor_out  <= head_job.divisor;
            cur_tag              <= head_job.tag;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (bus.div_valid_in) begin
            bus.quotient_out     <= bus.div_quotient_in;
            bus.remainder_out    <= bus.div_remainder_in;
            bus.error_out        <= bus.div_error_in;
            bus.tag_out          <= cur_tag;
            bus.result_valid_out <= 1'b1;
            state                <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.result_ready_in) begin
            bus.result_valid_out <= 1'b0;
            state                <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_job_scheduler.sv
// Scoreboard bench for div_job_scheduler driving a behavioural multi-cycle
// divider; expected results are queued at acceptance and popped by a monitor.
module tb_div_job_scheduler;

  localparam int W     = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          err;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exp_t exp_q[$];
  exp_t cur_exp;

  int checks            = 0;
  int errors            = 0;
  int cycle_cnt         = 0;
  int issue_cnt         = 0;
  int results_seen      = 0;
  int last_issue_cycle  = -1;
  int dvi_cycle         = -1;
  int last_accept_cycle = -1;
  int div_lat           = 3;
  int div_cnt           = 0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;

  always #5 clk = ~clk;

  div_job_scheduler_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus_if ();

  div_job_scheduler #(
    .WIDTH     (W),
    .DEPTH     (DEPTH),
    .TAG_WIDTH (TW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Stand-in for the real divider: busy the cycle after a start pulse,
  // result pulse div_lat cycles later, divide-by-zero gives error with q=r=0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_if.div_busy_in      <= 1'b0;
      bus_if.div_valid_in     <= 1'b0;
      bus_if.div_quotient_in  <= '0;
      bus_if.div_remainder_in <= '0;
      bus_if.div_error_in     <= 1'b0;
      div_cnt                 <= 0;
      div_a                   <= '0;
      div_b                   <= '0;
    end else begin
      bus_if.div_valid_in <= 1'b0;
      if (!bus_if.div_busy_in) begin
        if (bus_if.div_valid_out) begin
          bus_if.div_busy_in <= 1'b1;
          div_cnt            <= div_lat;
          div_a              <= bus_if.div_dividend_out;
          div_b              <= bus_if.div_divisor_out;
        end
      end else if (div_cnt <= 1) begin
        bus_if.div_busy_in  <= 1'b0;
        bus_if.div_valid_in <= 1'b1;
        if (div_b == '0) begin
          bus_if.div_quotient_in  <= '0;
          bus_if.div_remainder_in <= '0;
          bus_if.div_error_in     <= 1'b1;
        end else begin
          bus_if.div_quotient_in  <= div_a / div_b;
          bus_if.div_remainder_in <= div_a % div_b;
          bus_if.div_error_in     <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [95:0] packResult(input logic [W-1:0] q, input logic [W-1:0] r,
                                             input logic err, input logic [TW-1:0] tag);
    return 96'({q, r, err, tag});
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus_if.div_valid_out) begin
        issue_cnt++;
        last_issue_cycle = cycle_cnt;
      end
      if (bus_if.div_valid_in) dvi_cycle = cycle_cnt;
      if (bus_if.result_valid_out && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got tag %0d q %0d, expected no result",
                   bus_if.tag_out, bus_if.quotient_out);
        end else begin
          cur_exp = exp_q.pop_front();
          results_seen++;
          checkOutput("quotient", 96'(bus_if.quotient_out), 96'(cur_exp.q));
          checkOutput("remainder", 96'(bus_if.remainder_out), 96'(cur_exp.r));
          checkOutput("error", 96'(bus_if.error_out), 96'(cur_exp.err));
          checkOutput("tag", 96'(bus_if.tag_out), 96'(cur_exp.tag));
          checkOutput("result_latency", 96'(cycle_cnt), 96'(dvi_cycle + 1));
        end
      end else if (bus_if.result_valid_out) begin
        checkOutput("held_result",
                    packResult(bus_if.quotient_out, bus_if.remainder_out, bus_if.error_out, bus_if.tag_out),
                    packResult(cur_exp.q, cur_exp.r, cur_exp.err, cur_exp.tag));
      end
      prev_valid = bus_if.result_valid_out;
    end
  end

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("reset_req_ready", 96'(bus_if.req_ready_out), 96'(1));
    checkOutput("reset_valids", 96'({bus_if.result_valid_out, bus_if.div_valid_out}), 96'(0));
    checkOutput("reset_result_regs",
                packResult(bus_if.quotient_out, bus_if.remainder_out, bus_if.error_out, bus_if.tag_out), 96'(0));
    checkOutput("reset_div_regs", 96'({bus_if.div_dividend_out, bus_if.div_divisor_out}), 96'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue_cnt = 0;
  endtask

  // Called at a falling edge; holds the request until the scheduler takes it.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic eerr, input logic [TW-1:0] etag);
    int waited = 0;
    exp_t e;
    bus_if.dividend_in  = a;
    bus_if.divisor_in   = b;
    bus_if.req_valid_in = 1'b1;
    while (!bus_if.req_ready_out && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready_out stayed 0 for %0d cycles, required 1", waited);
      bus_if.req_valid_in = 1'b0;
      return;
    end
    e.q = eq; e.r = er; e.err = eerr; e.tag = etag;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    last_accept_cycle   = cycle_cnt;
    bus_if.req_valid_in = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus_if.result_valid_out) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: %0d results still pending after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    int n;
    bus_if.dividend_in     = '0;
    bus_if.divisor_in      = '0;
    bus_if.req_valid_in    = 1'b0;
    bus_if.result_ready_in = 1'b1;

    $display("[TB] single job 100/7");
    div_lat = 3;
    applyReset();
    applyStimulus(100, 7, 14, 2, 1'b0, 0);
    waitDrain("drain_single", 200);
    checkOutput("single_issue_count", 96'(issue_cnt), 96'(1));
    checkOutput("issue_latency", 96'(last_issue_cycle), 96'(last_accept_cycle + 1));

    $display("[TB] divide by zero then 9/3");
    applyReset();
    applyStimulus(55, 0, 0, 0, 1'b1, 0);
    applyStimulus(9, 3, 3, 0, 1'b0, 1);
    waitDrain("drain_div0", 200);

    $display("[TB] burst of 6 while divider busy");
    div_lat = 20;
    applyReset();
    applyStimulus(100, 7, 14, 2, 1'b0, 0);
    applyStimulus(81, 9, 9, 0, 1'b0, 1);
    applyStimulus(50, 3, 16, 2, 1'b0, 2);
    applyStimulus(7, 8, 0, 7, 1'b0, 3);
    applyStimulus(1000, 10, 100, 0, 1'b0, 4);
    #1;
    checkOutput("ready_when_full", 96'(bus_if.req_ready_out), 96'(0));
    applyStimulus(99, 0, 0, 0, 1'b1, 5);
    waitDrain("drain_burst", 1000);

    $display("[TB] consumer stalls 20 cycles");
    div_lat = 3;
    applyReset();
    bus_if.result_ready_in = 1'b0;
    applyStimulus(20, 6, 3, 2, 1'b0, 0);
    applyStimulus(40, 9, 4, 4, 1'b0, 1);
    n = 0;
    while (!bus_if.result_valid_out && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("stall_result_arrived", 96'(bus_if.result_valid_out), 96'(1));
    repeat (20) @(negedge clk);
    #1;
    checkOutput("no_issue_while_held", 96'(issue_cnt), 96'(1));
    checkOutput("valid_held_while_stalled", 96'(bus_if.result_valid_out), 96'(1));
    bus_if.result_ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reissue_within_2", 96'(issue_cnt), 96'(2));
    waitDrain("drain_stall", 200);

    $display("[TB] 17 jobs for tag wrap");
    div_lat = 1;
    applyReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(W'(7 * i + (i % 7)), 7, W'(i), W'(i % 7), 1'b0, TW'(i));
    end
    waitDrain("drain_wrap", 1000);

    $display("[TB] reset while waiting on divider");
    div_lat = 10;
    applyReset();
    applyStimulus(50, 5, 10, 0, 1'b0, 0);
    waitDrain("drain_pre_reset", 200);
    applyStimulus(30, 4, 7, 2, 1'b0, 1);
    applyStimulus(31, 4, 7, 3, 1'b0, 2);
    applyStimulus(32, 4, 8, 0, 1'b0, 3);
    n = 0;
    while (issue_cnt < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("second_job_issued", 96'(issue_cnt), 96'(2));
    repeat (3) @(negedge clk);
    snap = results_seen;
    applyReset();
    repeat (30) @(negedge clk);
    #1;
    checkOutput("no_result_after_reset", 96'(results_seen), 96'(snap));
    applyStimulus(8, 2, 4, 0, 1'b0, 0);
    waitDrain("drain_post_reset", 200);

    checkOutput("scoreboard_empty", 96'(exp_q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
